// File: rtl/calc_sequencer.sv
// calc_sequencer: central controller for the watchdog compute chain
// (param load -> eig_core compute -> output_loader serialise).
// Issues single-cycle start pulses and tracks core and output-loader
// handshakes. A watchdog timer sends the sequencer to ERR when KICK,
// WAIT_CORE or WAIT_OL outstays TIMEOUT_CYC enabled cycles.
// Optional build macro: SEQ_AUTO_REARM_EN. When defined, DONE goes straight
// back to LOAD so the chain runs continuously; otherwise DONE returns to
// IDLE and every run needs go.
module calc_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 1024,  // legal range 2..65535
    parameter int unsigned TMO_W       = 16     // 2**TMO_W must exceed TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       go,
    input  logic       ld_done,
    input  logic       core_busy,
    input  logic       core_done,
    input  logic       ol_busy,
    input  logic       err_clr,
    output logic       ld_clear,
    output logic       core_start,
    output logic       ol_start,
    output logic       done,
    output logic       seq_busy,
    output logic       seq_err,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_KICK      = 3'd2,
        S_WAIT_CORE = 3'd3,
        S_OUT       = 3'd4,
        S_WAIT_OL   = 3'd5,
        S_DONE      = 3'd6,
        S_ERR       = 3'd7
    } state_e;

    // Timer value seen in the last cycle the watchdog allows in a timed state.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] timer_q, timer_d;
    logic             ol_seen_q, ol_seen_d;
    logic             ld_clear_q, ld_clear_d;

    logic             tmo_hit;
    logic             timed_state;

    assign tmo_hit     = (timer_q == TMO_LAST);
    assign timed_state = (state_q == S_KICK) || (state_q == S_WAIT_CORE) ||
                         (state_q == S_WAIT_OL);

    // Pulse outputs: every one of them is masked by ena so a frozen block is silent.
    assign core_start = ena && (state_q == S_KICK) && !core_busy;
    assign ol_start   = ena && (state_q == S_OUT);
    assign done       = ena && (state_q == S_DONE);
    assign ld_clear   = ena && ld_clear_q;

    // Level outputs reflect the held state even while ena is low.
    assign seq_busy  = (state_q != S_IDLE) && (state_q != S_ERR);
    assign seq_err   = (state_q == S_ERR);
    assign seq_state = state_q;

    // Next-state, watchdog timer, ol_seen and ld_clear flag computation.
    always_comb begin
        // NOTE: every variable gets a hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        timer_d    = timer_q;
        ol_seen_d  = ol_seen_q;
        ld_clear_d = ld_clear_q;

        if (ena) begin
            // ld_clear lives only for the first enabled LOAD cycle.
            ld_clear_d = 1'b0;

            // Saturating count; entry into a timed state overrides it with zero.
            if (timed_state && (timer_q != TMO_MAX)) begin
                timer_d = timer_q + TMO_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_d    = S_LOAD;
                        ld_clear_d = 1'b1;
                    end
                end
                S_LOAD: begin
                    if (ld_done) begin
                        state_d = S_KICK;
                        timer_d = '0;
                    end
                end
                S_KICK: begin
                    // Handing the start to an idle core wins over a timeout.
                    if (core_start) begin
                        state_d = S_WAIT_CORE;
                        timer_d = '0;
                    end else if (tmo_hit) begin
                        state_d = S_ERR;
                    end
                end
                S_WAIT_CORE: begin
                    if (core_done) begin
                        state_d = S_OUT;
                    end else if (tmo_hit) begin
                        state_d = S_ERR;
                    end
                end
                S_OUT: begin
                    state_d   = S_WAIT_OL;
                    timer_d   = '0;
                    ol_seen_d = 1'b0;
                end
                S_WAIT_OL: begin
                    // Finish only after the loader has been seen busy and has gone idle.
                    if (ol_busy) begin
                        ol_seen_d = 1'b1;
                    end
                    if (!ol_busy && ol_seen_q) begin
                        state_d = S_DONE;
                    end else if (tmo_hit) begin
                        state_d = S_ERR;
                    end
                end
                S_DONE: begin
`ifdef SEQ_AUTO_REARM_EN
                    state_d    = S_LOAD;
                    ld_clear_d = 1'b1;
`else
                    state_d    = S_IDLE;
`endif
                end
                S_ERR: begin
                    // go is ignored here; it is sampled again once back in IDLE.
                    if (err_clr) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            ol_seen_q  <= 1'b0;
            ld_clear_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ol_seen_q  <= ol_seen_d;
            ld_clear_q <= ld_clear_d;
        end
    end

endmodule
